apb_master: RTL and testbench
=============================

# apb_master

Single-channel AMBA APB (APB3) requester that issues one transfer per start request on `ctl_fsm`. It sits between the system control logic and an APB slave or interconnect port. Transfers are generated internally as a write-then-readback sequence over an incrementing address range. The block implements standard SETUP/ACCESS phasing with PREADY wait states and samples PSLVERR.

## Interface
Clock is PCLK; reset is PRESET, asynchronous, active-low.

Parameters:
- ADDR_W, default 32: PADDR width.
- DATA_W, default 32: PWDATA/PRDATA width.
- BASE_ADDR, default 32'h0000_0000: first transfer address.
- ADDR_STEP, default 4: address increment per completed write/read pair.
- DATA_SEED, default 32'h1234_5678: first write data; increments by 1 per pair.

Ports:
- PCLK, input, 1: clock, rising edge.
- PRESET, input, 1: asynchronous active-low reset.
- ctl_fsm, input, 1: start request, sampled on PCLK.
- PADDR, output, ADDR_W: transfer address.
- PWDATA, output, DATA_W: write data.
- PWRITE, output, 1: 1 = write, 0 = read.
- PSEL, output, 1: slave select.
- PENABLE, output, 1: access phase.
- PRDATA, input, DATA_W: read data.
- PREADY, input, 1: slave completion.
- PSLVERR, input, 1: slave error, valid only when PSEL & PENABLE & PREADY.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE → SETUP when ctl_fsm = 1. Otherwise the FSM stays in IDLE.
- SETUP → ACCESS unconditionally after one cycle.
- ACCESS → ACCESS while PREADY = 0; wait states are unbounded.
- ACCESS with PREADY = 1 completes the transfer:
  - go to SETUP if ctl_fsm = 1 (back-to-back transfer);
  - otherwise go to IDLE.
- Output values per state:
  - IDLE: PSEL = 0, PENABLE = 0.
  - SETUP: PSEL = 1, PENABLE = 0.
  - ACCESS: PSEL = 1, PENABLE = 1.
- All outputs are registered.
- PADDR, PWRITE and PWDATA are loaded on entry to SETUP. They are held stable through ACCESS and after completion until the next SETUP.
- Transfer sequence, with phase bit ph and pair index n:
  - ph = 0 is a write: PADDR = BASE_ADDR + n·ADDR_STEP, PWDATA = DATA_SEED + n.
  - ph = 1 is a read of the same address. PWDATA keeps its last value.
- Advance rule: on completion, ph toggles. On a read completion, n also increments.
- Arithmetic wraps modulo 2^ADDR_W and 2^DATA_W.
- On read completion, PRDATA is captured into internal register rdata_q.
- On every completion, PSLVERR is captured into internal register err_q.
- Both rdata_q and err_q are hierarchically visible for verification.
- PREADY and PSLVERR are ignored outside ACCESS.
- ctl_fsm is ignored in SETUP and during ACCESS wait states.

## Timing
- Reset values:
  - PSEL = 0, PENABLE = 0, PWRITE = 0.
  - PADDR = BASE_ADDR, PWDATA = DATA_SEED.
  - state = IDLE, ph = 0, n = 0, rdata_q = 0, err_q = 0.
- Start latency: ctl_fsm sampled at edge k gives PSEL = 1 after edge k, and PENABLE = 1 after edge k+1.
- Minimum transfer is 2 cycles (SETUP plus one ACCESS cycle). Each PREADY-low ACCESS cycle adds one cycle.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronously). The sequence restarts at pair 0, write.

## Configuration
- Macro APB_MASTER_ERR_HOLD_EN.
- Defined: a completion with PSLVERR = 1 does not advance ph or n. The same transfer is reissued on the next start. rdata_q is not updated on an errored read.
- Undefined: the sequence advances regardless of PSLVERR. err_q still records the error.

## Structure
- Shared package apb_master_pkg holds:
  - typedef enum apb_state_e {IDLE, SETUP, ACCESS};
  - default constants for BASE_ADDR, ADDR_STEP and DATA_SEED.
- One sub-module, apb_master_seq, holds the ph/n counters and produces the next PADDR, PWDATA and PWRITE. It has an advance input and an err input.
- The top level holds the FSM and the output registers.

## Test plan
Defaults assumed: BASE_ADDR = 0, DATA_SEED = 0x1234_5678.
- Reset: hold PRESET = 0 → PSEL = PENABLE = PWRITE = 0, PADDR = 0, PWDATA = 0x1234_5678.
- Single write: pulse ctl_fsm for one cycle, with PREADY rising after 2 wait cycles.
  - Required: SETUP, then ACCESS for 3 cycles, with PWRITE = 1, PADDR = 0, PWDATA = 0x1234_5678; then IDLE.
- Readback: second start with PRDATA = 0xABCD_EF01 and PREADY = 1.
  - Required: PWRITE = 0, PADDR = 0, rdata_q = 0xABCD_EF01.
- Next pair: third start → PWRITE = 1, PADDR = 4, PWDATA = 0x1234_5679.
- Back-to-back: hold ctl_fsm = 1 with PREADY = 1 → ACCESS goes directly to SETUP, so PSEL stays 1 continuously.
- Error handling: PSLVERR = 1 while in IDLE → ignored.
  - PSLVERR = 1 with PREADY at completion → err_q = 1.
  - With APB_MASTER_ERR_HOLD_EN defined, the next start repeats the same PADDR/PWRITE.
  - Without the macro, the sequence advances.

Source files
------------

// File: rtl/apb_master_pkg.sv
// ============================================================================
// Module     : apb_master_pkg
// Description: Shared types and default constants for the APB requester.
//              Optional feature macro: APB_MASTER_ERR_HOLD_EN
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_master_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0000;
   localparam int unsigned DEF_ADDR_STEP = 4;
   localparam logic [31:0] DEF_DATA_SEED = 32'h1234_5678;

`ifdef APB_MASTER_ERR_HOLD_EN
   localparam bit ERR_HOLD_EN = 1'b1;
`else
   localparam bit ERR_HOLD_EN = 1'b0;
`endif

endpackage

`default_nettype wire

// File: rtl/apb_master_seq.sv
// ============================================================================
// Module     : apb_master_seq
// Description: Write/readback sequence counters (phase ph, pair index n) and
//              the address/data/direction of the transfer to issue next.
//              Optional feature macro: APB_MASTER_ERR_HOLD_EN
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master_seq
   import apb_master_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       DATA_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
   parameter int unsigned       ADDR_STEP = DEF_ADDR_STEP,
   parameter logic [DATA_W-1:0] DATA_SEED = DATA_W'(DEF_DATA_SEED)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              advance,
   input  logic              err,
   output logic [ADDR_W-1:0] next_addr,
   output logic [DATA_W-1:0] next_wdata,
   output logic              next_write
);

   localparam int unsigned N_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

   logic           ph_q;
   logic           ph_d;
   logic [N_W-1:0] n_q;
   logic [N_W-1:0] n_d;
   logic           step;
   logic [N_W-1:0] addr_full;
   logic [N_W-1:0] data_full;

   assign step = advance & ~(ERR_HOLD_EN & err);

   always_comb begin
      ph_d = ph_q;
      n_d  = n_q;
      if (step) begin
         ph_d = ~ph_q;
         if (ph_q) begin
            n_d = n_q + N_W'(1);
         end
      end
   end

   // Outputs follow the post-completion counters so a back-to-back SETUP
   // loads the advanced transfer on the same edge that completes the last.
   assign addr_full  = N_W'(BASE_ADDR) + n_d * N_W'(ADDR_STEP);
   assign data_full  = N_W'(DATA_SEED) + n_d;
   assign next_addr  = addr_full[ADDR_W-1:0];
   assign next_wdata = data_full[DATA_W-1:0];
   assign next_write = ~ph_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph_q <= 1'b0;
         n_q  <= '0;
      end else begin
         ph_q <= ph_d;
         n_q  <= n_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/apb_master.sv
// ============================================================================
// Module     : apb_master
// Description: APB3 requester issuing an incrementing write-then-readback
//              sequence, one transfer per start request.
//              Optional feature macro: APB_MASTER_ERR_HOLD_EN
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master
   import apb_master_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       DATA_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
   parameter int unsigned       ADDR_STEP = DEF_ADDR_STEP,
   parameter logic [DATA_W-1:0] DATA_SEED = DATA_W'(DEF_DATA_SEED)
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              ctl_fsm,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   output logic              PWRITE,
   output logic              PSEL,
   output logic              PENABLE,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   apb_state_e        state;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;
   logic              done;
   logic              start;
   logic [ADDR_W-1:0] next_addr;
   logic [DATA_W-1:0] next_wdata;
   logic              next_write;
   logic              unused_status;

   assign done  = (state == ACCESS) && PREADY;
   assign start = ctl_fsm && ((state == IDLE) || done);

   // Capture registers have no port; this keeps them read for lint.
   assign unused_status = ^{rdata_q, err_q};

   apb_master_seq #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .BASE_ADDR (BASE_ADDR),
      .ADDR_STEP (ADDR_STEP),
      .DATA_SEED (DATA_SEED)
   ) u_seq (
      .clk        (PCLK),
      .rst_n      (PRESET),
      .advance    (done),
      .err        (PSLVERR),
      .next_addr  (next_addr),
      .next_wdata (next_wdata),
      .next_write (next_write)
   );

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         state   <= IDLE;
         PSEL    <= 1'b0;
         PENABLE <= 1'b0;
         PWRITE  <= 1'b0;
         PADDR   <= BASE_ADDR;
         PWDATA  <= DATA_SEED;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ctl_fsm) begin
                  state <= SETUP;
                  PSEL  <= 1'b1;
               end
            end
            SETUP: begin
               state   <= ACCESS;
               PENABLE <= 1'b1;
            end
            ACCESS: begin
               if (PREADY) begin
                  err_q   <= PSLVERR;
                  PENABLE <= 1'b0;
                  if (!PWRITE && !(ERR_HOLD_EN && PSLVERR)) begin
                     rdata_q <= PRDATA;
                  end
                  if (ctl_fsm) begin
                     state <= SETUP;
                  end else begin
                     state <= IDLE;
                     PSEL  <= 1'b0;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               PSEL    <= 1'b0;
               PENABLE <= 1'b0;
            end
         endcase

         // Read transfers keep the previous write data on PWDATA.
         if (start) begin
            PADDR  <= next_addr;
            PWRITE <= next_write;
            if (next_write) begin
               PWDATA <= next_wdata;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_apb_master.sv
// ============================================================================
// Module     : tb_apb_master
// Description: Directed self-checking bench for apb_master (default params).
//              Expectations follow APB_MASTER_ERR_HOLD_EN when it is defined.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_master;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic        ctl     = 1'b0;
   logic [31:0] prdata  = '0;
   logic        pready  = 1'b0;
   logic        pslverr = 1'b0;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic        pwrite;
   logic        psel;
   logic        penable;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   apb_master dut (
      .PCLK    (clk),
      .PRESET  (rst_n),
      .ctl_fsm (ctl),
      .PADDR   (paddr),
      .PWDATA  (pwdata),
      .PWRITE  (pwrite),
      .PSEL    (psel),
      .PENABLE (penable),
      .PRDATA  (prdata),
      .PREADY  (pready),
      .PSLVERR (pslverr)
   );

   // Pulse start for one edge; returns at the negedge inside SETUP.
   task automatic start_xfer;
      ctl = 1'b1;
      @(negedge clk);
      ctl = 1'b0;
   endtask

   // With PREADY high: one ACCESS cycle, then back in IDLE.
   task automatic finish_xfer;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; ctl = 1'b0; pready = 1'b0; pslverr = 1'b0; prdata = '0;
      repeat (3) @(negedge clk);
      checks++; if ({psel, penable, pwrite} !== 3'b000) begin errors++;
         $display("FAIL reset_ctrl: psel/penable/pwrite=%b expected 000", {psel, penable, pwrite}); end
      checks++; if (paddr !== 32'h0) begin errors++;
         $display("FAIL reset_paddr: got %h expected 00000000", paddr); end
      checks++; if (pwdata !== 32'h1234_5678) begin errors++;
         $display("FAIL reset_pwdata: got %h expected 12345678", pwdata); end
      checks++; if ({dut.rdata_q, dut.err_q} !== 33'h0) begin errors++;
         $display("FAIL reset_capture: rdata_q=%h err_q=%b expected 0/0", dut.rdata_q, dut.err_q); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (psel !== 1'b0) begin errors++;
         $display("FAIL idle_hold: psel=%b expected 0", psel); end
   endtask

   task automatic test_single_write;
      pready = 1'b0;
      start_xfer();
      checks++; if ({psel, penable} !== 2'b10) begin errors++;
         $display("FAIL wr_setup: psel/penable=%b expected 10", {psel, penable}); end
      checks++; if ({pwrite, paddr, pwdata} !== {1'b1, 32'h0, 32'h1234_5678}) begin errors++;
         $display("FAIL wr_fields: pwrite=%b paddr=%h pwdata=%h expected 1/00000000/12345678", pwrite, paddr, pwdata); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if ({psel, penable} !== 2'b11) begin errors++;
            $display("FAIL wr_access%0d: psel/penable=%b expected 11", i, {psel, penable}); end
         if (i == 2) pready = 1'b1;
      end
      @(negedge clk);
      checks++; if ({psel, penable} !== 2'b00) begin errors++;
         $display("FAIL wr_done_idle: psel/penable=%b expected 00", {psel, penable}); end
      checks++; if ({pwrite, paddr} !== {1'b1, 32'h0}) begin errors++;
         $display("FAIL wr_hold: pwrite=%b paddr=%h expected 1/00000000", pwrite, paddr); end
      pready = 1'b0;
   endtask

   task automatic test_readback;
      prdata = 32'hABCD_EF01; pready = 1'b1;
      start_xfer();
      checks++; if ({psel, penable, pwrite, paddr} !== {3'b100, 32'h0}) begin errors++;
         $display("FAIL rd_setup: psel/penable/pwrite=%b paddr=%h expected 100/00000000", {psel, penable, pwrite}, paddr); end
      @(negedge clk);
      checks++; if ({psel, penable} !== 2'b11) begin errors++;
         $display("FAIL rd_access: psel/penable=%b expected 11", {psel, penable}); end
      @(negedge clk);
      checks++; if (dut.rdata_q !== 32'hABCD_EF01) begin errors++;
         $display("FAIL rd_capture: rdata_q=%h expected abcdef01", dut.rdata_q); end
      checks++; if ({psel, pwdata} !== {1'b0, 32'h1234_5678}) begin errors++;
         $display("FAIL rd_idle_pwdata: psel=%b pwdata=%h expected 0/12345678", psel, pwdata); end
      pready = 1'b0;
   endtask

   task automatic test_next_pair;
      pready = 1'b1;
      start_xfer();
      checks++; if ({pwrite, paddr, pwdata} !== {1'b1, 32'h4, 32'h1234_5679}) begin errors++;
         $display("FAIL pair1_fields: pwrite=%b paddr=%h pwdata=%h expected 1/00000004/12345679", pwrite, paddr, pwdata); end
      finish_xfer();
      pready = 1'b0;
   endtask

   task automatic test_back_to_back;
      logic [1:0]  exp_en   [6] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11};
      logic        exp_wr   [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [31:0] exp_addr [6] = '{32'h4, 32'h4, 32'h8, 32'h8, 32'h8, 32'h8};
      ctl = 1'b1; pready = 1'b1; prdata = 32'h5555_AAAA;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++; if ({psel, penable} !== exp_en[i]) begin errors++;
            $display("FAIL b2b_phase%0d: psel/penable=%b expected %b", i, {psel, penable}, exp_en[i]); end
         checks++; if ({pwrite, paddr} !== {exp_wr[i], exp_addr[i]}) begin errors++;
            $display("FAIL b2b_fields%0d: pwrite=%b paddr=%h expected %b/%h", i, pwrite, paddr, exp_wr[i], exp_addr[i]); end
      end
      ctl = 1'b0;
      @(negedge clk);
      checks++; if ({psel, penable} !== 2'b00) begin errors++;
         $display("FAIL b2b_end_idle: psel/penable=%b expected 00", {psel, penable}); end
      checks++; if ({dut.rdata_q, pwdata} !== {32'h5555_AAAA, 32'h1234_567A}) begin errors++;
         $display("FAIL b2b_data: rdata_q=%h pwdata=%h expected 5555aaaa/1234567a", dut.rdata_q, pwdata); end
      pready = 1'b0;
   endtask

   task automatic test_error;
      logic [32:0] exp_rep;
      logic [32:0] exp_last;
`ifdef APB_MASTER_ERR_HOLD_EN
      exp_rep  = {1'b1, 32'hC};
      exp_last = {1'b0, 32'hC};
`else
      exp_rep  = {1'b0, 32'hC};
      exp_last = {1'b0, 32'h10};
`endif
      pslverr = 1'b1; pready = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if ({psel, dut.err_q} !== 2'b00) begin errors++;
         $display("FAIL err_idle_ignored: psel=%b err_q=%b expected 0/0", psel, dut.err_q); end
      start_xfer();
      checks++; if ({pwrite, paddr, pwdata} !== {1'b1, 32'hC, 32'h1234_567B}) begin errors++;
         $display("FAIL err_wr_fields: pwrite=%b paddr=%h pwdata=%h expected 1/0000000c/1234567b", pwrite, paddr, pwdata); end
      finish_xfer();
      checks++; if (dut.err_q !== 1'b1) begin errors++;
         $display("FAIL err_capture: err_q=%b expected 1", dut.err_q); end
      pslverr = 1'b0;
      start_xfer();
      checks++; if ({pwrite, paddr} !== exp_rep) begin errors++;
         $display("FAIL err_next: pwrite/paddr=%h expected %h", {pwrite, paddr}, exp_rep); end
      finish_xfer();
      checks++; if (dut.err_q !== 1'b0) begin errors++;
         $display("FAIL err_clear: err_q=%b expected 0", dut.err_q); end
      pslverr = 1'b1; prdata = 32'hDEAD_BEEF;
      start_xfer();
      finish_xfer();
      checks++; if (dut.rdata_q !== 32'h5555_AAAA) begin errors++;
         $display("FAIL err_rdata_keep: rdata_q=%h expected 5555aaaa", dut.rdata_q); end
      pslverr = 1'b0;
      start_xfer();
      checks++; if ({pwrite, paddr} !== exp_last) begin errors++;
         $display("FAIL err_after: pwrite/paddr=%h expected %h", {pwrite, paddr}, exp_last); end
      finish_xfer();
      pready = 1'b0;
   endtask

   task automatic test_async_reset;
      pready = 1'b0;
      start_xfer();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({psel, penable, pwrite} !== 3'b000) begin errors++;
         $display("FAIL arst_ctrl: psel/penable/pwrite=%b expected 000", {psel, penable, pwrite}); end
      checks++; if ({paddr, pwdata} !== {32'h0, 32'h1234_5678}) begin errors++;
         $display("FAIL arst_fields: paddr=%h pwdata=%h expected 00000000/12345678", paddr, pwdata); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pready = 1'b1;
      start_xfer();
      checks++; if ({pwrite, paddr, pwdata} !== {1'b1, 32'h0, 32'h1234_5678}) begin errors++;
         $display("FAIL arst_restart: pwrite=%b paddr=%h pwdata=%h expected 1/00000000/12345678", pwrite, paddr, pwdata); end
      finish_xfer();
      pready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_readback();
      test_next_pair();
      test_back_to_back();
      test_error();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
